// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - two-port read arbiter in front of the single-port DSR ROM
//
// Shares one registered-read ROM (1-cycle latency) between port A (TI bus DSR fetch)
// and port B (Pi readback/verify). At most one read is granted per clock. A normally
// wins; B is forced through one slot after waiting STARVE_MAX cycles. Read data is
// steered back to its owner two clocks after the ack, with a one-cycle valid strobe.
//
// Ports
//   i_clk        primary clock, all state on posedge
//   i_reset_n    asynchronous active-low reset
//   i_a_req      port A read request, held with i_a_addr until o_a_ack
//   i_a_addr     port A byte address [0:12], bit 0 = MSB
//   o_a_ack      combinational grant for port A
//   o_a_valid    one-cycle strobe, o_a_data holds a new A result
//   o_a_data     last A read result [0:7], held until the next A result
//   i_b_req      port B read request, held with i_b_addr until o_b_ack
//   i_b_addr     port B byte address [0:12]
//   o_b_ack      combinational grant for port B
//   o_b_valid    one-cycle strobe for o_b_data
//   o_b_data     last B read result [0:7]
//   o_rom_addr   ROM address [0:12], sampled by the ROM on posedge
//   i_rom_data   ROM read data [0:7], valid the cycle after the address is sampled

module rom_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_a_req,
  input  logic [0:12] i_a_addr,
  output logic        o_a_ack,
  output logic        o_a_valid,
  output logic [0:7]  o_a_data,
  input  logic        i_b_req,
  input  logic [0:12] i_b_addr,
  output logic        o_b_ack,
  output logic        o_b_valid,
  output logic [0:7]  o_b_data,
  output logic [0:12] o_rom_addr,
  input  logic [0:7]  i_rom_data
);

  localparam logic             STARVE_EN  = (STARVE_MAX != 0);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // starvation counter: cycles B has waited while A was granted
  logic [CNT_W-1:0] r_cnt;

  // stage 1 of the owner pipeline: a read was issued to the ROM at the last edge
  logic             r_s1_vld;
  logic             r_s1_own_b;

  // stage 2: captured results and their strobes
  logic             r_a_valid;
  logic [0:7]       r_a_data;
  logic             r_b_valid;
  logic [0:7]       r_b_data;

  logic             w_force_b;
  logic             w_a_ack;
  logic             w_b_ack;
  logic             w_issue;
  logic             w_b_wait;
  logic             w_cap_a;
  logic             w_cap_b;

  // Grant. B only beats a requesting A once it has been starved long enough;
  // a_ack is derived from b_ack so the two can never be high together.
  always_comb begin
    w_force_b = 1'b0;
    w_b_ack   = 1'b0;
    w_a_ack   = 1'b0;
    w_force_b = STARVE_EN && (r_cnt >= STARVE_LIM);
    w_b_ack   = i_b_req && (!i_a_req || w_force_b);
    w_a_ack   = i_a_req && !w_b_ack;
  end

  // Idle cycles still present A's address; a ROM read has no side effects.
  always_comb begin
    o_rom_addr = i_a_addr;
    if (w_b_ack) begin
      o_rom_addr = i_b_addr;
    end
  end

  always_comb begin
    w_issue  = w_a_ack || w_b_ack;
    // b_req without b_ack implies A took the slot
    w_b_wait = i_b_req && !w_b_ack;
    w_cap_a  = r_s1_vld && !r_s1_own_b;
    w_cap_b  = r_s1_vld &&  r_s1_own_b;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (w_b_wait) begin
      if (r_cnt != CNT_SAT) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  // Clearing stage 1 on reset drops any read already issued, so no strobe
  // appears for a request granted before reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_own_b <= 1'b0;
    end else begin
      r_s1_vld   <= w_issue;
      r_s1_own_b <= w_b_ack;
    end
  end

  // The ROM output is valid during the cycle after issue; capture it into the
  // owner's data register only, leaving the other port's result untouched.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_a_valid <= 1'b0;
      r_a_data  <= 8'h00;
      r_b_valid <= 1'b0;
      r_b_data  <= 8'h00;
    end else begin
      r_a_valid <= w_cap_a;
      r_b_valid <= w_cap_b;
      if (w_cap_a) begin
        r_a_data <= i_rom_data;
      end
      if (w_cap_b) begin
        r_b_data <= i_rom_data;
      end
    end
  end

  assign o_a_ack   = w_a_ack;
  assign o_b_ack   = w_b_ack;
  assign o_a_valid = r_a_valid;
  assign o_a_data  = r_a_data;
  assign o_b_valid = r_b_valid;
  assign o_b_data  = r_b_data;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - self-checking bench for rom_arbiter
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_req, b_req;
  logic [0:12] a_addr, b_addr;

  logic        a_ack, a_valid, b_ack, b_valid;
  logic [0:7]  a_data, b_data, rom_q;
  logic [0:12] rom_addr;

  logic        a_ack1, a_valid1, b_ack1, b_valid1;
  logic [0:7]  a_data1, b_data1, rom_q1;
  logic [0:12] rom_addr1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rom_arbiter #(.STARVE_MAX(4), .CNT_W(4)) u_dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_a_req(a_req), .i_a_addr(a_addr), .o_a_ack(a_ack), .o_a_valid(a_valid), .o_a_data(a_data),
    .i_b_req(b_req), .i_b_addr(b_addr), .o_b_ack(b_ack), .o_b_valid(b_valid), .o_b_data(b_data),
    .o_rom_addr(rom_addr), .i_rom_data(rom_q)
  );

  rom_arbiter #(.STARVE_MAX(0), .CNT_W(4)) u_dut_nostarve (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_a_req(a_req), .i_a_addr(a_addr), .o_a_ack(a_ack1), .o_a_valid(a_valid1), .o_a_data(a_data1),
    .i_b_req(b_req), .i_b_addr(b_addr), .o_b_ack(b_ack1), .o_b_valid(b_valid1), .o_b_data(b_data1),
    .o_rom_addr(rom_addr1), .i_rom_data(rom_q1)
  );

  // ROM contents: low address byte ^ high address bits ^ 8'hAA (ROM[0] = 8'hAA)
  function automatic logic [7:0] rom_fn(input logic [0:12] a);
    logic [12:0] t;
    t = a;
    return t[7:0] ^ {3'b000, t[12:8]} ^ 8'hAA;
  endfunction

  always @(posedge clk) begin
    rom_q  <= rom_fn(rom_addr);
    rom_q1 <= rom_fn(rom_addr1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        a_req;
    logic [12:0] a_addr;
    logic        b_req;
    logic [12:0] b_addr;
    logic        ea_ack;
    logic        eb_ack;
    logic        ea_v;
    logic [7:0]  ea_d;
    logic        eb_v;
    logic [7:0]  eb_d;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ar, input logic [12:0] aa, input logic br, input logic [12:0] ba,
                     input logic eaa, input logic eba, input logic eav, input logic [7:0] ead,
                     input logic ebv, input logic [7:0] ebd);
    vec_t v;
    v.a_req = ar; v.a_addr = aa; v.b_req = br; v.b_addr = ba;
    v.ea_ack = eaa; v.eb_ack = eba; v.ea_v = eav; v.ea_d = ead; v.eb_v = ebv; v.eb_d = ebd;
    vecs.push_back(v);
  endtask

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  initial begin
    reset_n = 1'b0;
    a_req = 1'b0; b_req = 1'b0; a_addr = '0; b_addr = '0;

    // A only, then simultaneous A/B, then A stream at top of ROM, then B at 13'h1FFF
    add(1, 13'h0000, 0, 13'h0000, 1, 0, 0, 8'h00, 0, 8'h00);
    add(0, 13'h0000, 0, 13'h0000, 0, 0, 0, 8'h00, 0, 8'h00);
    add(0, 13'h0000, 0, 13'h0000, 0, 0, 1, 8'hAA, 0, 8'h00);
    add(0, 13'h0000, 0, 13'h0000, 0, 0, 0, 8'hAA, 0, 8'h00);
    add(1, 13'h0010, 1, 13'h0020, 1, 0, 0, 8'hAA, 0, 8'h00);
    add(0, 13'h0000, 1, 13'h0020, 0, 1, 0, 8'hAA, 0, 8'h00);
    add(0, 13'h0000, 0, 13'h0000, 0, 0, 1, 8'hBA, 0, 8'h00);
    add(0, 13'h0000, 0, 13'h0000, 0, 0, 0, 8'hBA, 1, 8'h8A);
    add(0, 13'h0000, 0, 13'h0000, 0, 0, 0, 8'hBA, 0, 8'h8A);
    add(1, 13'h1FFC, 0, 13'h0000, 1, 0, 0, 8'hBA, 0, 8'h8A);
    add(1, 13'h1FFD, 0, 13'h0000, 1, 0, 0, 8'hBA, 0, 8'h8A);
    add(1, 13'h1FFE, 0, 13'h0000, 1, 0, 1, 8'h49, 0, 8'h8A);
    add(1, 13'h1FFF, 0, 13'h0000, 1, 0, 1, 8'h48, 0, 8'h8A);
    add(0, 13'h0000, 0, 13'h0000, 0, 0, 1, 8'h4B, 0, 8'h8A);
    add(0, 13'h0000, 0, 13'h0000, 0, 0, 1, 8'h4A, 0, 8'h8A);
    add(0, 13'h0000, 0, 13'h0000, 0, 0, 0, 8'h4A, 0, 8'h8A);
    add(0, 13'h0000, 1, 13'h1FFF, 0, 1, 0, 8'h4A, 0, 8'h8A);
    add(0, 13'h0000, 0, 13'h0000, 0, 0, 0, 8'h4A, 0, 8'h8A);
    add(0, 13'h0000, 0, 13'h0000, 0, 0, 0, 8'h4A, 1, 8'h4A);
    add(0, 13'h0000, 0, 13'h0000, 0, 0, 0, 8'h4A, 0, 8'h4A);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ack", a_ack, 0);
    chk("rst_b_ack", b_ack, 0);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_a_data", a_data, 8'h00);
    chk("rst_b_data", b_data, 8'h00);
    next_cycle();
    reset_n = 1'b1;

    // table vectors, one per cycle
    foreach (vecs[i]) begin
      a_req = vecs[i].a_req; a_addr = vecs[i].a_addr;
      b_req = vecs[i].b_req; b_addr = vecs[i].b_addr;
      @(negedge clk);
      chk($sformatf("vec%0d_a_ack", i), a_ack, vecs[i].ea_ack);
      chk($sformatf("vec%0d_b_ack", i), b_ack, vecs[i].eb_ack);
      chk($sformatf("vec%0d_a_valid", i), a_valid, vecs[i].ea_v);
      chk($sformatf("vec%0d_a_data", i), a_data, vecs[i].ea_d);
      chk($sformatf("vec%0d_b_valid", i), b_valid, vecs[i].eb_v);
      chk($sformatf("vec%0d_b_data", i), b_data, vecs[i].eb_d);
      next_cycle();
    end

    // starvation: A every cycle, B held; forced B slot every 5th cycle with STARVE_MAX=4
    for (int k = 1; k <= 12; k++) begin
      a_req = 1'b1; a_addr = 13'(k); b_req = 1'b1; b_addr = 13'h0100;
      @(negedge clk);
      chk($sformatf("starve%0d_b_ack", k), b_ack, (k % 5) == 0);
      chk($sformatf("starve%0d_a_ack", k), a_ack, (k % 5) != 0);
      chk($sformatf("starve%0d_nb_b_ack", k), b_ack1, 0);
      chk($sformatf("starve%0d_nb_a_ack", k), a_ack1, 1);
      next_cycle();
    end
    a_req = 1'b0; b_req = 1'b0;
    repeat (3) next_cycle();

    // reset pulsed between grant and capture
    a_req = 1'b1; a_addr = 13'h0055;
    @(negedge clk);
    chk("rstmid_grant", a_ack, 1);
    next_cycle();
    a_req = 1'b0;
    #2 reset_n = 1'b0;
    @(negedge clk);
    chk("rstmid_a_data", a_data, 8'h00);
    chk("rstmid_b_data", b_data, 8'h00);
    chk("rstmid_a_valid", a_valid, 0);
    #2 reset_n = 1'b1;
    a_req = 1'b1; a_addr = 13'h0123;
    #1 chk("rstrel_a_ack", a_ack, 1);
    next_cycle();
    a_req = 1'b0;
    @(negedge clk);
    chk("rstrel_no_stale_valid", a_valid, 0);
    chk("rstrel_no_stale_b", b_valid, 0);
    next_cycle();
    @(negedge clk);
    chk("rstrel_a_valid", a_valid, 1);
    chk("rstrel_a_data", a_data, 8'h88);
    next_cycle();
    @(negedge clk);
    chk("rstrel_a_valid_end", a_valid, 0);
    next_cycle();

    // random traffic against a scoreboard
    begin
      logic a_acked, b_acked;
      a_acked = 1'b1; b_acked = 1'b1;
      for (int cyc = 0; cyc < 260; cyc++) begin
        if (cyc >= 250) begin
          a_req = 1'b0; b_req = 1'b0;
        end else begin
          if (a_acked || !a_req) begin
            a_req = 1'($urandom_range(0, 1)); a_addr = 13'($urandom);
          end
          if (b_acked || !b_req) begin
            b_req = 1'($urandom_range(0, 1)); b_addr = 13'($urandom);
          end
        end
        @(negedge clk);
        chk("rnd_mutex", a_ack & b_ack, 0);
        begin
          logic ea, eb;
          ea = (qa.size() > 0) && (qa[0].due == cyc);
          eb = (qb.size() > 0) && (qb[0].due == cyc);
          chk($sformatf("rnd%0d_a_valid", cyc), a_valid, ea);
          chk($sformatf("rnd%0d_b_valid", cyc), b_valid, eb);
          if (ea) begin
            chk($sformatf("rnd%0d_a_data", cyc), a_data, qa[0].data);
            void'(qa.pop_front());
          end
          if (eb) begin
            chk($sformatf("rnd%0d_b_data", cyc), b_data, qb[0].data);
            void'(qb.pop_front());
          end
        end
        if (a_ack) qa.push_back('{due: cyc + 2, data: rom_fn(a_addr)});
        if (b_ack) qb.push_back('{due: cyc + 2, data: rom_fn(b_addr)});
        a_acked = a_ack; b_acked = b_ack;
        next_cycle();
      end
      chk("rnd_a_drained", qa.size(), 0);
      chk("rnd_b_drained", qb.size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
